axis_width_upsizer: RTL and testbench



---
 rtl/axis_pkg.sv | 23 ++
 rtl/axis_out_slice.sv | 57 +++++
 rtl/axis_width_upsizer.sv | 185 ++++++++++++++++++
 tb/tb_axis_width_upsizer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream width upsizer and its output slice.
//   AXIS_BYTE        : bits per byte lane
//   AXIS_DATA_WIDTH  : default packed word width
//   upsizer_state_e  : upsizer FSM states (COLLECT, STALL)
//   strb_width()     : number of strobe bits for a given data width
// -----------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_BYTE       = 8;
    localparam int AXIS_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } upsizer_state_e;

    function automatic int strb_width(input int data_width);
        return data_width / AXIS_BYTE;
    endfunction

endpackage

// File: rtl/axis_out_slice.sv
// -----------------------------------------------------------------------------
// axis_out_slice
// One-word registered AXI-Stream output stage. A load writes a word and raises
// tvalid; a handshake without a coincident load clears tvalid. The word stays
// stable while tvalid=1 and tready=0. The producer must only load when the slot
// is free (!tvalid || tready).
// Ports:
//   axis_aclk, axis_areset : clock, synchronous active-high reset
//   load, load_data, load_strb, load_last : word to capture this edge
//   tready                 : downstream accept
//   tvalid, tdata, tstrb, tlast : registered stream outputs
// -----------------------------------------------------------------------------
module axis_out_slice import axis_pkg::*; #(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int STRB_WIDTH = strb_width(AXIS_DATA_WIDTH)
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [STRB_WIDTH-1:0] load_strb,
    input  logic                  load_last,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [STRB_WIDTH-1:0] tstrb,
    output logic                  tlast
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [STRB_WIDTH-1:0] strb_r;
    logic                  last_r;

    // Output word register with valid/ready hold behaviour.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            strb_r  <= {STRB_WIDTH{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            strb_r  <= load_strb;
            last_r  <= load_last;
        end else if (valid_r && tready) begin
            valid_r <= 1'b0;
        end
    end

    assign tvalid = valid_r;
    assign tdata  = data_r;
    assign tstrb  = strb_r;
    assign tlast  = last_r;

endmodule

// File: rtl/axis_width_upsizer.sv
// -----------------------------------------------------------------------------
// axis_width_upsizer
// Packs narrow AXI-Stream beats little-endian into DATA_WIDTH words with
// per-byte tstrb; tlast closes a (possibly partial) word so packet boundaries
// are preserved. Unfilled lanes carry tdata=0 and tstrb=0.
// Ports:
//   axis_aclk, axis_areset       : clock, synchronous active-high reset
//   s00_axis_t{data,strb,valid,last,ready} : narrow input stream
//   m00_axis_t{data,strb,valid,last,ready} : wide output stream
//   s00_axis_flush               : only with AXIS_UPSIZER_FLUSH_EN defined;
//                                  closes a non-empty partial word with tlast=0
// Optional build macro: AXIS_UPSIZER_FLUSH_EN
// -----------------------------------------------------------------------------
module axis_width_upsizer import axis_pkg::*; #(
    parameter int IN_WIDTH   = AXIS_BYTE,
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [IN_WIDTH-1:0]     s00_axis_tdata,
    input  logic [IN_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready
`ifdef AXIS_UPSIZER_FLUSH_EN
    ,
    input  logic                    s00_axis_flush
`endif
);

    // RATIO must be at least 2; a 1:1 configuration is not a width change.
    localparam int RATIO    = DATA_WIDTH / IN_WIDTH;
    localparam int CNT_W    = $clog2(RATIO);
    localparam int IN_STRB  = strb_width(IN_WIDTH);
    localparam int OUT_STRB = strb_width(DATA_WIDTH);

    upsizer_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic [DATA_WIDTH-1:0] acc_data_r, acc_data_nxt_s;
    logic [OUT_STRB-1:0]   acc_strb_r, acc_strb_nxt_s;
    logic                  acc_last_r, acc_last_nxt_s;
    logic                  s_tready_r;

    logic                  beat_s;
    logic                  word_end_s;
    logic                  slot_free_s;
    logic [DATA_WIDTH-1:0] beat_data_s;
    logic [OUT_STRB-1:0]   beat_strb_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [OUT_STRB-1:0]   load_strb_s;
    logic                  load_last_s;

    assign beat_s      = s00_axis_tvalid && s_tready_r;
    assign word_end_s  = (cnt_r == CNT_W'(RATIO - 1)) || s00_axis_tlast;
    assign slot_free_s = !m00_axis_tvalid || m00_axis_tready;

    // The accumulator is zero above the current lane, so OR-ing in the shifted
    // beat both places it and keeps unfilled lanes at zero.
    assign beat_data_s = acc_data_r | (DATA_WIDTH'(s00_axis_tdata) << (int'(cnt_r) * IN_WIDTH));
    assign beat_strb_s = acc_strb_r | (OUT_STRB'(s00_axis_tstrb) << (int'(cnt_r) * IN_STRB));

    // Next-state, accumulator update and output-slice load decisions.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        acc_data_nxt_s = acc_data_r;
        acc_strb_nxt_s = acc_strb_r;
        acc_last_nxt_s = acc_last_r;
        load_s         = 1'b0;
        load_data_s    = beat_data_s;
        load_strb_s    = beat_strb_s;
        load_last_s    = s00_axis_tlast;
        case (state_r)
            COLLECT: begin
                if (beat_s && word_end_s) begin
                    if (slot_free_s) begin
                        load_s         = 1'b1;
                        cnt_nxt_s      = {CNT_W{1'b0}};
                        acc_data_nxt_s = {DATA_WIDTH{1'b0}};
                        acc_strb_nxt_s = {OUT_STRB{1'b0}};
                        acc_last_nxt_s = 1'b0;
                    end else begin
                        acc_data_nxt_s = beat_data_s;
                        acc_strb_nxt_s = beat_strb_s;
                        acc_last_nxt_s = s00_axis_tlast;
                        state_nxt_s    = STALL;
                    end
                end else if (beat_s) begin
                    acc_data_nxt_s = beat_data_s;
                    acc_strb_nxt_s = beat_strb_s;
                    cnt_nxt_s      = cnt_r + CNT_W'(1);
                end
`ifdef AXIS_UPSIZER_FLUSH_EN
                // A flush only acts on a cycle without an accepted beat, which
                // defers a coincident flush to the next idle cycle.
                else if (s00_axis_flush && (cnt_r != {CNT_W{1'b0}})) begin
                    load_data_s = acc_data_r;
                    load_strb_s = acc_strb_r;
                    load_last_s = 1'b0;
                    if (slot_free_s) begin
                        load_s         = 1'b1;
                        cnt_nxt_s      = {CNT_W{1'b0}};
                        acc_data_nxt_s = {DATA_WIDTH{1'b0}};
                        acc_strb_nxt_s = {OUT_STRB{1'b0}};
                        acc_last_nxt_s = 1'b0;
                    end else begin
                        acc_last_nxt_s = 1'b0;
                        state_nxt_s    = STALL;
                    end
                end
`endif
                else begin
                    state_nxt_s = COLLECT;
                end
            end
            STALL: begin
                load_data_s = acc_data_r;
                load_strb_s = acc_strb_r;
                load_last_s = acc_last_r;
                if (slot_free_s) begin
                    load_s         = 1'b1;
                    cnt_nxt_s      = {CNT_W{1'b0}};
                    acc_data_nxt_s = {DATA_WIDTH{1'b0}};
                    acc_strb_nxt_s = {OUT_STRB{1'b0}};
                    acc_last_nxt_s = 1'b0;
                    state_nxt_s    = COLLECT;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            default: begin
                state_nxt_s    = COLLECT;
                cnt_nxt_s      = {CNT_W{1'b0}};
                acc_data_nxt_s = {DATA_WIDTH{1'b0}};
                acc_strb_nxt_s = {OUT_STRB{1'b0}};
                acc_last_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter, accumulator and registered input-ready.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_r    <= COLLECT;
            cnt_r      <= {CNT_W{1'b0}};
            acc_data_r <= {DATA_WIDTH{1'b0}};
            acc_strb_r <= {OUT_STRB{1'b0}};
            acc_last_r <= 1'b0;
            s_tready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            acc_data_r <= acc_data_nxt_s;
            acc_strb_r <= acc_strb_nxt_s;
            acc_last_r <= acc_last_nxt_s;
            s_tready_r <= (state_nxt_s == COLLECT);
        end
    end

    assign s00_axis_tready = s_tready_r;

    axis_out_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (OUT_STRB)
    ) u_out_slice (
        .axis_aclk   (axis_aclk),
        .axis_areset (axis_areset),
        .load        (load_s),
        .load_data   (load_data_s),
        .load_strb   (load_strb_s),
        .load_last   (load_last_s),
        .tready      (m00_axis_tready),
        .tvalid      (m00_axis_tvalid),
        .tdata       (m00_axis_tdata),
        .tstrb       (m00_axis_tstrb),
        .tlast       (m00_axis_tlast)
    );

endmodule

// File: tb/tb_axis_width_upsizer.sv
module tb_axis_width_upsizer;

    logic        axis_aclk = 1'b0;
    logic        axis_areset;
    logic [7:0]  s00_axis_tdata;
    logic [0:0]  s00_axis_tstrb;
    logic        s00_axis_tvalid;
    logic        s00_axis_tlast;
    logic        s00_axis_tready;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;
    logic        m00_axis_tvalid;
    logic        m00_axis_tlast;
    logic        m00_axis_tready;
`ifdef AXIS_UPSIZER_FLUSH_EN
    logic        s00_axis_flush;
`endif

    axis_width_upsizer #(.IN_WIDTH(8), .DATA_WIDTH(32)) dut (
        .axis_aclk       (axis_aclk),
        .axis_areset     (axis_areset),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tstrb  (s00_axis_tstrb),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tready (s00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready)
`ifdef AXIS_UPSIZER_FLUSH_EN
        ,
        .s00_axis_flush  (s00_axis_flush)
`endif
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned xfer_cyc_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cycle = 0;
    int          stall_cnt = 0;

    always @(posedge axis_aclk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        exp_q.push_back('{data: d, strb: s, last: l});
    endtask

    // Scoreboard monitor plus hold-stability check under backpressure.
    exp_t        mon_w;
    logic        hold_pend = 1'b0;
    logic [36:0] hold_val;
    always @(negedge axis_aclk) begin
        if (hold_pend)
            check("hold_stable", {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata},
                  {1'b1, hold_val[36:0]});
        if (m00_axis_tvalid && m00_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=0x%0h required=none", m00_axis_tdata);
            end else begin
                mon_w = exp_q.pop_front();
                check("word", {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata},
                      {mon_w.last, mon_w.strb, mon_w.data});
            end
            xfer_cyc_q.push_back(cycle);
        end
        hold_pend = m00_axis_tvalid && !m00_axis_tready && !axis_areset;
        hold_val  = {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
    end

    task automatic send(input logic [7:0] d, input logic s, input logic l);
        bit done = 1'b0;
        s00_axis_tdata  = d;
        s00_axis_tstrb  = s;
        s00_axis_tlast  = l;
        s00_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge axis_aclk);
            if (s00_axis_tready) done = 1'b1;
            else stall_cnt++;
            @(posedge axis_aclk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge axis_aclk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int unsigned gap;
        axis_areset     = 1'b1;
        s00_axis_tdata  = 8'h00;
        s00_axis_tstrb  = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        m00_axis_tready = 1'b1;
`ifdef AXIS_UPSIZER_FLUSH_EN
        s00_axis_flush  = 1'b0;
`endif
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_s_tready", 64'(s00_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m00_axis_tvalid), 64'd0);
        check("rst_m_tdata",  64'(m00_axis_tdata),  64'd0);
        check("rst_m_tstrb",  64'(m00_axis_tstrb),  64'd0);
        check("rst_m_tlast",  64'(m00_axis_tlast),  64'd0);
        @(posedge axis_aclk); #1;
        axis_areset = 1'b0;
        @(negedge axis_aclk);
        check("tready_pre_edge", 64'(s00_axis_tready), 64'd0);
        @(posedge axis_aclk); #1;
        check("tready_rise", 64'(s00_axis_tready), 64'd1);

        // Full word with one-cycle latency.
        expect_word(32'h44332211, 4'hF, 1'b1);
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        check("pre_latency_valid", 64'(m00_axis_tvalid), 64'd0);
        send(8'h44, 1'b1, 1'b1);
        check("latency_valid", 64'(m00_axis_tvalid), 64'd1);
        drain("drain_full");

        // Partial word, tlast on beat 0, strobe-0 beat keeps its lane.
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b1, 1'b1);
        expect_word(32'h0000005A, 4'h1, 1'b1);
        send(8'h5A, 1'b1, 1'b1);
        expect_word(32'h00C3C2C1, 4'h5, 1'b1);
        send(8'hC1, 1'b1, 1'b0);
        send(8'hC2, 1'b0, 1'b0);
        send(8'hC3, 1'b1, 1'b1);
        drain("drain_partial");

        // Backpressure: 12 beats with the downstream stalled.
        @(posedge axis_aclk); #1;
        m00_axis_tready = 1'b0;
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        expect_word(32'h0C0B0A09, 4'hF, 1'b1);
        fork
            begin
                for (int i = 1; i <= 12; i++) send(8'(i), 1'b1, (i == 12));
            end
            begin
                repeat (15) @(posedge axis_aclk);
                @(negedge axis_aclk);
                check("stall_s_tready", 64'(s00_axis_tready), 64'd0);
                check("stall_held_word", {31'd0, m00_axis_tvalid, m00_axis_tdata}, {31'd0, 1'b1, 32'h04030201});
                @(posedge axis_aclk); #1;
                m00_axis_tready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Back-to-back: no input stall, words spaced by four cycles.
        stall_cnt = 0;
        xfer_cyc_q.delete();
        expect_word(32'hA3A2A1A0, 4'hF, 1'b0);
        expect_word(32'hA7A6A5A4, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b1, (i == 7));
        drain("drain_b2b");
        check("b2b_input_stalls", 64'(stall_cnt), 64'd0);
        check("b2b_word_count", 64'(xfer_cyc_q.size()), 64'd2);
        gap = (xfer_cyc_q.size() >= 2) ? (xfer_cyc_q[1] - xfer_cyc_q[0]) : 0;
        check("b2b_valid_spacing", 64'(gap), 64'd4);

        // Reset mid-word drops the partial word.
        send(8'h55, 1'b1, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        axis_areset = 1'b1;
        @(posedge axis_aclk); #1;
        check("midrst_s_tready", 64'(s00_axis_tready), 64'd0);
        check("midrst_outputs", {27'd0, m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata}, 64'd0);
        axis_areset = 1'b0;
        expect_word(32'h74737271, 4'hF, 1'b1);
        send(8'h71, 1'b1, 1'b0);
        send(8'h72, 1'b1, 1'b0);
        send(8'h73, 1'b1, 1'b0);
        send(8'h74, 1'b1, 1'b1);
        drain("drain_after_reset");

`ifdef AXIS_UPSIZER_FLUSH_EN
        // Flush closes a 3-beat partial word; the next beat starts in lane 0.
        expect_word(32'h00333231, 4'h7, 1'b0);
        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        s00_axis_flush = 1'b1;
        @(posedge axis_aclk); #1;
        s00_axis_flush = 1'b0;
        expect_word(32'h00000034, 4'h1, 1'b1);
        send(8'h34, 1'b1, 1'b1);
        drain("drain_flush");
`endif

        repeat (5) @(posedge axis_aclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
